roi_readout_seq: RTL

Parametrised row/column readout sequencer for the imager, driving the CDS, pixel-reset and output-mux signals. It replaces the fixed full-frame pixel-clock FSM with a single-clock (ADC_CLK) design that derives its own pixel-rate enable. It supports a programmable row window with row skipping, runtime phase lengths and a parametrised ADC-latency data-valid pipeline. It sits between the exposure FSM (start/done handshake) and the TI-ADC capture path.

---
 rtl/roi_readout_seq_pkg.sv | 19 +
 rtl/roi_readout_seq_if.sv | 39 +++
 rtl/roi_readout_seq_valid_dly.sv | 32 +++
 rtl/roi_readout_seq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/roi_readout_seq_pkg.sv
// Shared types and widths for the ROI readout sequencer.
package roi_pkg;

  // Width of the programmable phase-length fields (PHI1_LEN / PHI2_LEN).
  localparam int PH_W = 8;

  // Width of the completed-frame counter.
  localparam int FRAME_W = 16;

  // Readout sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PH1    = 3'd1,
    PH2    = 3'd2,
    MUX    = 3'd3,
    DONE_W = 3'd4
  } roi_state_t;

endpackage

// File: rtl/roi_readout_seq_if.sv
// Control bus between the exposure FSM (master) and the readout sequencer (slave).
//
// Handshakes:
//   START/START_ACK: master raises START as a level and holds it together with
//   the window/phase configuration. The sequencer samples START on a pixel-rate
//   edge while idle; a legal window is accepted with a one-pixel-period
//   START_ACK pulse, an illegal one raises CFG_ERR instead and no START_ACK is
//   given. START left high after a frame re-arms the next frame.
//   DONE/DONE_ACK: the sequencer raises DONE at end of frame and holds it until
//   it samples DONE_ACK high on a pixel-rate edge; DONE then drops.
interface roi_readout_seq_if #(
  parameter int ROW_W = 8
) ();
  import roi_pkg::*;

  logic               START;
  logic               START_ACK;
  logic               DONE;
  logic               DONE_ACK;
  logic [ROW_W-1:0]   ROW_FIRST;
  logic [ROW_W-1:0]   ROW_LAST;
  logic [ROW_W-1:0]   ROW_STEP;
  logic [PH_W-1:0]    PHI1_LEN;
  logic [PH_W-1:0]    PHI2_LEN;
  logic               CFG_ERR;
  logic               BUSY;
  logic [FRAME_W-1:0] FRAME_CNT;

  modport master (
    output START, DONE_ACK, ROW_FIRST, ROW_LAST, ROW_STEP, PHI1_LEN, PHI2_LEN,
    input  START_ACK, DONE, CFG_ERR, BUSY, FRAME_CNT
  );

  modport slave (
    input  START, DONE_ACK, ROW_FIRST, ROW_LAST, ROW_STEP, PHI1_LEN, PHI2_LEN,
    output START_ACK, DONE, CFG_ERR, BUSY, FRAME_CNT
  );

endinterface

// File: rtl/roi_readout_seq_valid_dly.sv
// Fixed-latency single-bit delay line with synchronous clear; dout is din
// delayed by exactly DEPTH clock cycles.
module roi_valid_dly #(
  parameter int DEPTH = 24
) (
  input  logic clk,
  input  logic clr,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] sr;

  generate
    if (DEPTH == 1) begin : g_one
      // Single-stage delay.
      always_ff @(posedge clk) begin
        if (clr) sr <= '0;
        else     sr <= din;
      end
    end else begin : g_many
      // Shift din in at bit 0 every cycle; the oldest sample leaves at the top.
      always_ff @(posedge clk) begin
        if (clr) sr <= '0;
        else     sr <= {sr[DEPTH-2:0], din};
      end
    end
  endgenerate

  assign dout = sr[DEPTH-1];

endmodule

// File: rtl/roi_readout_seq.sv
// Row/column readout sequencer: walks a programmable row window, driving the
// CDS phases, pixel reset and output-driver mux at a pixel rate derived from
// ADC_CLK, and produces an ADC data-valid delayed by the ADC latency.
module roi_readout_seq
  import roi_pkg::*;
#(
  parameter int NUM_ROWS  = 160,
  parameter int NUM_MUX   = 46,
  parameter int PIX_DIV   = 3,
  parameter int PRECH_LEN = 1,
  parameter int TLAT      = 24,
  parameter int ROW_W     = $clog2(NUM_ROWS + 1),
  parameter int MUX_W     = $clog2(NUM_MUX + 1)
) (
  input  logic             ADC_CLK,
  input  logic             RESET,
  roi_readout_seq_if.slave ctl,
  output logic             PHI1,
  output logic             PRECH_COL,
  output logic             PIXRES,
  output logic [ROW_W-1:0] ROW_ADD,
  output logic [MUX_W-1:0] MUX_ADD,
  output logic             PRECHN_AMP,
  output logic             ADC_DATA_VALID,
  output roi_state_t       dbg_state
);

  localparam int DIV_W = $clog2(PIX_DIV);
  localparam logic [PH_W-1:0]  PRECH_L  = PH_W'(PRECH_LEN);
  localparam logic [ROW_W-1:0] ROW_PARK = ROW_W'(NUM_ROWS);
  localparam logic [MUX_W-1:0] MUX_PARK = MUX_W'(NUM_MUX);
  localparam logic [MUX_W-1:0] MUX_END  = MUX_W'(NUM_MUX - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             pix_en;

  roi_state_t state, nxt_state;
  logic [PH_W-1:0]    ph_cnt, nxt_ph_cnt;
  logic [ROW_W-1:0]   cfg_last, nxt_cfg_last;
  logic [ROW_W-1:0]   cfg_step, nxt_cfg_step;
  logic [PH_W-1:0]    cfg_p1, nxt_cfg_p1;
  logic [PH_W-1:0]    cfg_p2, nxt_cfg_p2;

  logic               start_ack, nxt_start_ack;
  logic               done, nxt_done;
  logic               cfg_err, nxt_cfg_err;
  logic               busy, nxt_busy;
  logic [FRAME_W-1:0] frame_cnt, nxt_frame_cnt;
  logic               nxt_phi1, nxt_prech_col, nxt_pixres, nxt_amp;
  logic [ROW_W-1:0]   nxt_row;
  logic [MUX_W-1:0]   nxt_mux;

  logic [ROW_W:0]     row_sum;
  logic               bad_window;

  assign pix_en     = (div_cnt == DIV_W'(PIX_DIV - 1));
  // Next row computed one bit wider so a large step cannot wrap back into the window.
  assign row_sum    = {1'b0, ROW_ADD} + {1'b0, cfg_step};
  assign bad_window = (ctl.ROW_FIRST > ctl.ROW_LAST) || (ctl.ROW_LAST >= ROW_PARK);

  // Next-state and next-output decode, applied only on pixel-rate edges.
  always_comb begin
    nxt_state     = state;
    nxt_ph_cnt    = ph_cnt;
    nxt_cfg_last  = cfg_last;
    nxt_cfg_step  = cfg_step;
    nxt_cfg_p1    = cfg_p1;
    nxt_cfg_p2    = cfg_p2;
    nxt_start_ack = 1'b0;
    nxt_done      = done;
    nxt_cfg_err   = cfg_err;
    nxt_frame_cnt = frame_cnt;
    nxt_phi1      = PHI1;
    nxt_prech_col = PRECH_COL;
    nxt_pixres    = PIXRES;
    nxt_amp       = PRECHN_AMP;
    nxt_row       = ROW_ADD;
    nxt_mux       = MUX_ADD;

    case (state)
      IDLE: begin
        if (ctl.START) begin
          if (bad_window) begin
            nxt_cfg_err = 1'b1;
          end else begin
            nxt_cfg_err   = 1'b0;
            nxt_start_ack = 1'b1;
            nxt_row       = ctl.ROW_FIRST;
            nxt_cfg_last  = ctl.ROW_LAST;
            nxt_cfg_step  = (ctl.ROW_STEP == '0) ? ROW_W'(1) : ctl.ROW_STEP;
            nxt_cfg_p1    = (ctl.PHI1_LEN == '0) ? PH_W'(1) : ctl.PHI1_LEN;
            nxt_cfg_p2    = (ctl.PHI2_LEN == '0) ? PH_W'(1) : ctl.PHI2_LEN;
            nxt_ph_cnt    = '0;
            nxt_phi1      = 1'b1;
            nxt_prech_col = (PRECH_L != '0);
            nxt_state     = PH1;
          end
        end
      end

      PH1: begin
        if (ph_cnt == cfg_p1 - PH_W'(1)) begin
          nxt_phi1      = 1'b0;
          nxt_prech_col = 1'b0;
          nxt_pixres    = 1'b1;
          nxt_ph_cnt    = '0;
          nxt_state     = PH2;
        end else begin
          nxt_ph_cnt    = ph_cnt + PH_W'(1);
          nxt_prech_col = ((ph_cnt + PH_W'(1)) < PRECH_L);
        end
      end

      PH2: begin
        if (ph_cnt == cfg_p2 - PH_W'(1)) begin
          nxt_pixres = 1'b0;
          nxt_amp    = 1'b1;
          nxt_mux    = '0;
          nxt_ph_cnt = '0;
          nxt_state  = MUX;
        end else begin
          nxt_ph_cnt = ph_cnt + PH_W'(1);
        end
      end

      MUX: begin
        if (MUX_ADD == MUX_END) begin
          nxt_amp = 1'b0;
          nxt_mux = MUX_PARK;
          if (row_sum <= {1'b0, cfg_last}) begin
            nxt_row       = row_sum[ROW_W-1:0];
            nxt_ph_cnt    = '0;
            nxt_phi1      = 1'b1;
            nxt_prech_col = (PRECH_L != '0);
            nxt_state     = PH1;
          end else begin
            nxt_row       = ROW_PARK;
            nxt_frame_cnt = frame_cnt + FRAME_W'(1);
            nxt_done      = 1'b1;
            nxt_state     = DONE_W;
          end
        end else begin
          nxt_mux = MUX_ADD + MUX_W'(1);
        end
      end

      DONE_W: begin
        if (ctl.DONE_ACK) begin
          nxt_done  = 1'b0;
          nxt_state = IDLE;
        end
      end

      default: nxt_state = IDLE;
    endcase

    nxt_busy = (nxt_state != IDLE);
  end

  // Pixel-rate divider plus all FSM state and registered outputs.
  always_ff @(posedge ADC_CLK) begin
    if (RESET) begin
      div_cnt    <= '0;
      state      <= IDLE;
      ph_cnt     <= '0;
      cfg_last   <= '0;
      cfg_step   <= ROW_W'(1);
      cfg_p1     <= PH_W'(1);
      cfg_p2     <= PH_W'(1);
      start_ack  <= 1'b0;
      done       <= 1'b0;
      cfg_err    <= 1'b0;
      busy       <= 1'b0;
      frame_cnt  <= '0;
      PHI1       <= 1'b0;
      PRECH_COL  <= 1'b0;
      PIXRES     <= 1'b0;
      PRECHN_AMP <= 1'b0;
      ROW_ADD    <= ROW_PARK;
      MUX_ADD    <= MUX_PARK;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + DIV_W'(1);
      if (pix_en) begin
        state      <= nxt_state;
        ph_cnt     <= nxt_ph_cnt;
        cfg_last   <= nxt_cfg_last;
        cfg_step   <= nxt_cfg_step;
        cfg_p1     <= nxt_cfg_p1;
        cfg_p2     <= nxt_cfg_p2;
        start_ack  <= nxt_start_ack;
        done       <= nxt_done;
        cfg_err    <= nxt_cfg_err;
        busy       <= nxt_busy;
        frame_cnt  <= nxt_frame_cnt;
        PHI1       <= nxt_phi1;
        PRECH_COL  <= nxt_prech_col;
        PIXRES     <= nxt_pixres;
        PRECHN_AMP <= nxt_amp;
        ROW_ADD    <= nxt_row;
        MUX_ADD    <= nxt_mux;
      end
    end
  end

  assign ctl.START_ACK = start_ack;
  assign ctl.DONE      = done;
  assign ctl.CFG_ERR   = cfg_err;
  assign ctl.BUSY      = busy;
  assign ctl.FRAME_CNT = frame_cnt;
  assign dbg_state     = state;

  roi_valid_dly #(
    .DEPTH(TLAT)
  ) u_valid_dly (
    .clk (ADC_CLK),
    .clr (RESET),
    .din (PRECHN_AMP),
    .dout(ADC_DATA_VALID)
  );

endmodule
